fp_addsub_arbiter: RTL

- Shares one combinational fp add/sub unit (sig_width/exp_width/ieee_compliance instance) among NUM_REQ requesters.
- Round-robin arbitration feeds a registered operand stage that drives the shared unit.
- The unit's result and status are captured in a registered response stage, which is returned on a single tagged response channel with backpressure.
- Sits between vector/accumulator clients and the shared adder.

---
 rtl/fp_addsub_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fp_addsub_arbiter.sv
// rtl/fp_addsub_arbiter.sv - round-robin front end sharing one combinational fp add/sub unit
// Two registered stages: operand stage driving the shared unit, and a tagged response stage.
module fp_addsub_arbiter #(
    parameter int sig_width = 23,
    parameter int exp_width = 8,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_REQ-1:0]                           req_valid,
    output logic [NUM_REQ-1:0]                           req_ready,
    input  logic [NUM_REQ*(sig_width+exp_width+1)-1:0]   req_a,
    input  logic [NUM_REQ*(sig_width+exp_width+1)-1:0]   req_b,
    input  logic [NUM_REQ*3-1:0]                         req_rnd,
    input  logic [NUM_REQ-1:0]                           req_op,
    output logic [sig_width+exp_width:0]                 fu_a,
    output logic [sig_width+exp_width:0]                 fu_b,
    output logic [2:0]                                   fu_rnd,
    output logic                                         fu_op,
    input  logic [sig_width+exp_width:0]                 fu_z,
    input  logic [7:0]                                   fu_status,
    output logic                                         rsp_valid,
    input  logic                                         rsp_ready,
    output logic [sig_width+exp_width:0]                 rsp_z,
    output logic [7:0]                                   rsp_status,
    output logic [ID_W-1:0]                              rsp_id
);
    localparam int W = sig_width + exp_width + 1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic            s1_v_q, s1_v_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [W-1:0]    fu_a_q, fu_a_d, fu_b_q, fu_b_d;
    logic [2:0]      fu_rnd_q, fu_rnd_d;
    logic            fu_op_q, fu_op_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_z_q, rsp_z_d;
    logic [7:0]      rsp_status_q, rsp_status_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;

    logic            adv2, accept, xfer, gnt_found;
    logic [ID_W-1:0] gnt;

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt       = ID_W'(idx);
            end
        end
    end

    assign adv2   = s1_v_q & (~rsp_valid_q | rsp_ready);
    assign accept = ~s1_v_q | adv2;
    assign xfer   = gnt_found & accept;

    always_comb begin
        req_ready = '0;
        if (rst_n && xfer) req_ready[gnt] = 1'b1;
    end

    always_comb begin
        s1_id_d      = s1_id_q;
        ptr_d        = ptr_q;
        fu_a_d       = fu_a_q;
        fu_b_d       = fu_b_q;
        fu_rnd_d     = fu_rnd_q;
        fu_op_d      = fu_op_q;
        rsp_z_d      = rsp_z_q;
        rsp_status_d = rsp_status_q;
        rsp_id_d     = rsp_id_q;
        if (xfer) begin
            fu_a_d   = req_a[gnt*W +: W];
            fu_b_d   = req_b[gnt*W +: W];
            fu_rnd_d = req_rnd[gnt*3 +: 3];
            fu_op_d  = req_op[gnt];
            s1_id_d  = gnt;
            ptr_d    = (gnt == LAST_ID) ? '0 : gnt + 1'b1;
        end
        // Shared unit output is only ever registered here, never passed through.
        if (adv2) begin
            rsp_z_d      = fu_z;
            rsp_status_d = fu_status;
            rsp_id_d     = s1_id_q;
        end
        s1_v_d      = xfer | (s1_v_q & ~adv2);
        rsp_valid_d = adv2 | (rsp_valid_q & ~rsp_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q       <= 1'b0;
            s1_id_q      <= '0;
            ptr_q        <= '0;
            fu_a_q       <= '0;
            fu_b_q       <= '0;
            fu_rnd_q     <= '0;
            fu_op_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_z_q      <= '0;
            rsp_status_q <= '0;
            rsp_id_q     <= '0;
        end else begin
            s1_v_q       <= s1_v_d;
            s1_id_q      <= s1_id_d;
            ptr_q        <= ptr_d;
            fu_a_q       <= fu_a_d;
            fu_b_q       <= fu_b_d;
            fu_rnd_q     <= fu_rnd_d;
            fu_op_q      <= fu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_z_q      <= rsp_z_d;
            rsp_status_q <= rsp_status_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign fu_a       = fu_a_q;
    assign fu_b       = fu_b_q;
    assign fu_rnd     = fu_rnd_q;
    assign fu_op      = fu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_z      = rsp_z_q;
    assign rsp_status = rsp_status_q;
    assign rsp_id     = rsp_id_q;
endmodule
